// File: rtl/dw_fifo_s1_sf_if.sv
// Handshake/data bundle for the single-clock FWFT FIFO.
// The producer/consumer side uses master; the FIFO uses slave.
interface dw_fifo_s1_sf_if #(
  parameter int width = 32
);

  logic             push_req_n;
  logic             pop_req_n;
  logic             diag_n;
  logic [width-1:0] data_in;
  logic [width-1:0] data_out;
  logic             empty;
  logic             almost_empty;
  logic             half_full;
  logic             almost_full;
  logic             full;
  logic             error;

  modport master (
    output push_req_n,
    output pop_req_n,
    output diag_n,
    output data_in,
    input  data_out,
    input  empty,
    input  almost_empty,
    input  half_full,
    input  almost_full,
    input  full,
    input  error
  );

  modport slave (
    input  push_req_n,
    input  pop_req_n,
    input  diag_n,
    input  data_in,
    output data_out,
    output empty,
    output almost_empty,
    output half_full,
    output almost_full,
    output full,
    output error
  );

endinterface

// File: rtl/dw_fifo_s1_sf.sv
// Single-clock first-word-fall-through FIFO with registered status flags.
// Define DW_FIFO_S1_SF_MEM_RESET_EN to also clear storage on reset.
module dw_fifo_s1_sf #(
  parameter int width    = 32,
  parameter int depth    = 4,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 2
) (
  input  logic           clock,
  input  logic           reset,
  dw_fifo_s1_sf_if.slave bus
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  localparam logic [PW-1:0] LAST   = PW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AE_C   = CW'(ae_level);
  localparam logic [CW-1:0] AF_C   = CW'(depth - af_level);
  localparam logic [CW-1:0] HF_C   = CW'((depth + 1) / 2);

  // Reject illegal configurations at elaboration time.
  if (width < 1 || width > 256) begin : g_bad_width
    $error("dw_fifo_s1_sf: width=%0d outside 1..256", width);
  end
  if (depth < 2 || depth > 256) begin : g_bad_depth
    $error("dw_fifo_s1_sf: depth=%0d outside 2..256", depth);
  end
  if (ae_level < 1 || ae_level > depth - 1) begin : g_bad_ae
    $error("dw_fifo_s1_sf: ae_level=%0d outside 1..depth-1",
           ae_level);
  end
  if (af_level < 1 || af_level > depth - 1) begin : g_bad_af
    $error("dw_fifo_s1_sf: af_level=%0d outside 1..depth-1",
           af_level);
  end
  if (err_mode < 0 || err_mode > 2) begin : g_bad_err
    $error("dw_fifo_s1_sf: err_mode=%0d outside 0..2", err_mode);
  end

  logic [width-1:0] mem_q [depth];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_q, empty_d;
  logic almost_empty_q, almost_empty_d;
  logic half_full_q, half_full_d;
  logic almost_full_q, almost_full_d;
  logic full_q, full_d;
  logic error_q, error_d;

  logic push_ok;
  logic pop_ok;
  logic ovf;
  logic unf;
  logic ptr_bad;

  logic [CW:0] occ;
  logic [CW:0] occ_exp;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Accept/reject decisions use the current occupancy, not the flags.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (!bus.push_req_n) begin
      if (count_q == DEPTH_C) ovf = 1'b1;
      else                    push_ok = 1'b1;
    end
    if (!bus.pop_req_n) begin
      if (count_q == '0) unf = 1'b1;
      else               pop_ok = 1'b1;
    end
  end

  // Next pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = nxt(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = nxt(rd_ptr_q);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer distance must agree with the stored count.
  always_comb begin
    occ     = '0;
    occ_exp = '0;
    if (wr_ptr_q >= rd_ptr_q) begin
      occ = (CW+1)'(wr_ptr_q) - (CW+1)'(rd_ptr_q);
    end else begin
      occ = (CW+1)'(wr_ptr_q) + (CW+1)'(depth)
          - (CW+1)'(rd_ptr_q);
    end
    if (count_q == DEPTH_C) occ_exp = '0;
    else                    occ_exp = (CW+1)'(count_q);
    ptr_bad = (occ != occ_exp) || (count_q > DEPTH_C);
  end

  // Status flags are a function of the post-edge count.
  always_comb begin
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_C);
    almost_empty_d = (count_d <= AE_C);
    almost_full_d  = (count_d >= AF_C);
    half_full_d    = (count_d >= HF_C);
  end

  // Error flag: sticky with diag clear, sticky, or one-cycle pulse.
  always_comb begin
    error_d = 1'b0;
    if (err_mode == 0) begin
      if (!bus.diag_n) error_d = 1'b0;
      else error_d = error_q | ovf | unf | ptr_bad;
    end else if (err_mode == 1) begin
      error_d = error_q | ovf | unf;
    end else begin
      error_d = ovf | unf;
    end
  end

  // Control state and registered flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      half_full_q    <= 1'b0;
      almost_full_q  <= 1'b0;
      full_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      half_full_q    <= half_full_d;
      almost_full_q  <= almost_full_d;
      full_q         <= full_d;
      error_q        <= error_d;
    end
  end

  // Storage write; reset only blocks the write unless storage clear is built in.
  always_ff @(posedge clock) begin
`ifdef DW_FIFO_S1_SF_MEM_RESET_EN
    if (reset) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
`else
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
`endif
  end

  assign bus.data_out     = mem_q[rd_ptr_q];
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.half_full    = half_full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.full         = full_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_dw_fifo_s1_sf.sv
// Scoreboard bench for dw_fifo_s1_sf at width 32, depth 4, err_mode 2.
// A queue models contents; flags and error are derived from its size.
module tb_dw_fifo_s1_sf;

  localparam int W = 32;
  localparam int D = 4;

  logic clock;
  logic reset;

  int checks;
  int errors;

  logic [W-1:0] sb[$];

  dw_fifo_s1_sf_if #(.width(W)) bus ();

  dw_fifo_s1_sf #(
    .width(W),
    .depth(D),
    .ae_level(1),
    .af_level(1),
    .err_mode(2)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_flags();
    int n;
    n = sb.size();
    chk("empty", W'(bus.empty), W'(n == 0));
    chk("almost_empty", W'(bus.almost_empty), W'(n <= 1));
    chk("half_full", W'(bus.half_full), W'(n >= 2));
    chk("almost_full", W'(bus.almost_full), W'(n >= 3));
    chk("full", W'(bus.full), W'(n == D));
    if (n > 0) chk("head", bus.data_out, sb[0]);
  endtask

  task automatic idle();
    bus.push_req_n = 1'b1;
    bus.pop_req_n  = 1'b1;
    bus.data_in    = '0;
  endtask

  // One clock: drive, score the pop before the edge, check after it.
  task automatic cyc(input bit push, input bit pop,
                     input logic [W-1:0] d);
    int n;
    bit exp_err;
    logic [W-1:0] tmp;
    bus.push_req_n = ~push;
    bus.pop_req_n  = ~pop;
    bus.data_in    = d;
    #1;
    n = sb.size();
    exp_err = (push && n == D) || (pop && n == 0);
    if (pop && n > 0) begin
      chk("pop_data", bus.data_out, sb[0]);
      tmp = sb.pop_front();
    end
    if (push && n < D) sb.push_back(d);
    @(posedge clock);
    #1;
    idle();
    chk_flags();
    chk("error", W'(bus.error), W'(exp_err));
  endtask

  task automatic do_reset(input int k, input bit push);
    reset = 1'b1;
    bus.push_req_n = ~push;
    bus.data_in = 32'hDEAD_BEEF;
    repeat (k) @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    sb.delete();
    chk_flags();
    chk("reset_error", W'(bus.error), '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.diag_n = 1'b1;
    idle();
    @(posedge clock);
    #1;

    do_reset(2, 1'b0);

    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    cyc(1, 0, 32'h33);
    cyc(1, 0, 32'h44);
    repeat (4) cyc(0, 1, '0);

    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    cyc(1, 0, 32'h33);
    cyc(1, 0, 32'h44);
    cyc(1, 1, 32'h55);
    chk("ovf_head", bus.data_out, 32'h22);
    repeat (3) cyc(0, 1, '0);

    cyc(0, 1, '0);
    cyc(0, 0, '0);
    cyc(1, 1, 32'h66);
    chk("unf_push_head", bus.data_out, 32'h66);

    cyc(1, 0, 32'h0A);
    cyc(0, 1, '0);
    cyc(1, 0, 32'h0B);
    chk("wrap_start", bus.data_out, 32'h0A);
    for (int i = 0; i < 10; i++) cyc(1, 1, 32'h0C + W'(i));
    repeat (2) cyc(0, 1, '0);

    cyc(1, 0, 32'hA1);
    cyc(1, 0, 32'hA2);
    cyc(1, 0, 32'hA3);
    do_reset(1, 1'b1);
    cyc(1, 0, 32'h77);
    cyc(0, 1, '0);

    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
